// File: rtl/powerup_sprite_ctrl_pkg.sv
// Shared types and constants for the power-up sprite controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package powerup_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHOWN  = 2'd1,
    ST_BLINK  = 2'd2,
    ST_EXPIRE = 2'd3
  } state_e;

  localparam logic [4:0] REG_BITMAP = 5'd0;
  localparam logic [4:0] REG_X0     = 5'd1;
  localparam logic [4:0] REG_Y0     = 5'd2;
  localparam logic [4:0] REG_LIFE   = 5'd3;
  localparam logic [4:0] REG_STATUS = 5'd4;
  localparam logic [4:0] REG_PAL1   = 5'd5;
  localparam logic [4:0] REG_PAL2   = 5'd6;
  localparam logic [4:0] REG_PAL3   = 5'd7;

  localparam int SPRITE_DIM = 16;

  localparam logic [11:0] PAL1_DEFAULT = 12'hF00;
  localparam logic [11:0] PAL2_DEFAULT = 12'h0F0;
  localparam logic [11:0] PAL3_DEFAULT = 12'hFF0;

endpackage

// File: rtl/powerup_sprite_ctrl_ram.sv
// Simple dual-port bitmap RAM, one write port and one registered read port.
// Latency: read data 1 clk after raddr; same-address read/write returns old data.
// Backpressure: none, accepts a write and a read every cycle.
module powerup_sprite_ctrl_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // Storage is deliberately not reset; the read register samples before the write lands.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
    rdata_q <= mem_q[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/powerup_sprite_ctrl.sv
// Power-up sprite overlay: bitmap scan, lifetime FSM, bus registers (POWERUP_PALETTE_EN adds palette regs 5..7).
// Latency: so_rgb is 2 clk after x/y/si_rgb; register writes take effect the next clk.
// Backpressure: none, streaming pixel path and a bus that always accepts.
module powerup_sprite_ctrl
  import powerup_pkg::*;
#(
  parameter int CD                = 12,
  parameter int BLINK_FRAMES      = 60,
  parameter int BLINK_PERIOD_LOG2 = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cs,
  input  logic          write,
  input  logic [4:0]    addr,
  input  logic [31:0]   wr_data,
  output logic [31:0]   rd_data,
  input  logic          frame_start,
  input  logic [10:0]   x,
  input  logic [10:0]   y,
  input  logic [CD-1:0] si_rgb,
  output logic [CD-1:0] so_rgb,
  output logic          expired
);

  localparam logic [15:0] BLINK_LIMIT = 16'(BLINK_FRAMES);

  logic wr_en;
  logic life_wr;
  logic bm_we;
  assign wr_en   = cs & write;
  assign life_wr = wr_en && (addr == REG_LIFE);
  assign bm_we   = wr_en && (addr == REG_BITMAP);

  state_e                       state_q, state_d;
  logic [15:0]                  life_q, life_d, life_dec;
  logic [BLINK_PERIOD_LOG2-1:0] blink_cnt_q, blink_cnt_d;
  logic                         blink_phase_q, blink_phase_d;
  logic                         expired_q, expired_d;
  logic [10:0]                  x0_q, x0_d, y0_q, y0_d;
  logic [CD-1:0]                pal1, pal2, pal3;

  assign life_dec = life_q - 16'd1;

  // Lifetime FSM next state: a life write overrides any frame tick in the same cycle.
  always_comb begin
    state_d       = state_q;
    life_d        = life_q;
    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    expired_d     = expired_q;
    if (wr_en && (addr == REG_STATUS) && wr_data[0]) expired_d = 1'b0;
    if (life_wr) begin
      life_d        = wr_data[15:0];
      blink_cnt_d   = '0;
      blink_phase_d = 1'b0;
      if (wr_data[15:0] == 16'd0)             state_d = ST_IDLE;
      else if (wr_data[15:0] <= BLINK_LIMIT)  state_d = ST_BLINK;
      else                                    state_d = ST_SHOWN;
    end else begin
      case (state_q)
        ST_SHOWN: begin
          if (frame_start) begin
            life_d = life_dec;
            if (life_dec <= BLINK_LIMIT) state_d = ST_BLINK;
          end
        end
        ST_BLINK: begin
          if (frame_start) begin
            life_d      = life_dec;
            blink_cnt_d = blink_cnt_q + 1'b1;
            if (blink_cnt_q == {BLINK_PERIOD_LOG2{1'b1}}) blink_phase_d = ~blink_phase_q;
            if (life_dec == 16'd0) state_d = ST_EXPIRE;
          end
        end
        ST_EXPIRE: begin
          state_d       = ST_IDLE;
          blink_cnt_d   = '0;
          blink_phase_d = 1'b0;
        end
        default: ;
      endcase
    end
    // Expiry flag is set on the EXPIRE cycle even if a clear or reload arrives with it.
    if (state_q == ST_EXPIRE) expired_d = 1'b1;
  end

  // Sprite origin registers.
  always_comb begin
    x0_d = x0_q;
    y0_d = y0_q;
    if (wr_en && (addr == REG_X0)) x0_d = wr_data[10:0];
    if (wr_en && (addr == REG_Y0)) y0_d = wr_data[10:0];
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      life_q        <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      expired_q     <= 1'b0;
      x0_q          <= '0;
      y0_q          <= '0;
    end else begin
      state_q       <= state_d;
      life_q        <= life_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      expired_q     <= expired_d;
      x0_q          <= x0_d;
      y0_q          <= y0_d;
    end
  end

`ifdef POWERUP_PALETTE_EN
  logic [CD-1:0] pal1_q, pal1_d, pal2_q, pal2_d, pal3_q, pal3_d;

  // Bus-writable palette entries for colour indices 1..3.
  always_comb begin
    pal1_d = pal1_q;
    pal2_d = pal2_q;
    pal3_d = pal3_q;
    if (wr_en && (addr == REG_PAL1)) pal1_d = wr_data[CD-1:0];
    if (wr_en && (addr == REG_PAL2)) pal2_d = wr_data[CD-1:0];
    if (wr_en && (addr == REG_PAL3)) pal3_d = wr_data[CD-1:0];
  end

  // Palette registers come up at the fixed default colours.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pal1_q <= CD'(PAL1_DEFAULT);
      pal2_q <= CD'(PAL2_DEFAULT);
      pal3_q <= CD'(PAL3_DEFAULT);
    end else begin
      pal1_q <= pal1_d;
      pal2_q <= pal2_d;
      pal3_q <= pal3_d;
    end
  end

  assign pal1 = pal1_q;
  assign pal2 = pal2_q;
  assign pal3 = pal3_q;
`else
  assign pal1 = CD'(PAL1_DEFAULT);
  assign pal2 = CD'(PAL2_DEFAULT);
  assign pal3 = CD'(PAL3_DEFAULT);
`endif

  // Register read mux; write-only and unused addresses read as zero.
  always_comb begin
    rd_data = '0;
    case (addr)
      REG_X0:     rd_data = {21'd0, x0_q};
      REG_Y0:     rd_data = {21'd0, y0_q};
      REG_LIFE:   rd_data = {16'd0, life_q};
      REG_STATUS: rd_data = {29'd0, state_q, expired_q};
`ifdef POWERUP_PALETTE_EN
      REG_PAL1:   rd_data = 32'(pal1);
      REG_PAL2:   rd_data = 32'(pal2);
      REG_PAL3:   rd_data = 32'(pal3);
`endif
      default: ;
    endcase
  end

  // Stage 0: wrap-safe offsets, so pixels left of or above the origin give huge dx/dy and miss.
  logic [10:0] dx, dy;
  logic        hit, visible;
  logic [7:0]  ram_raddr;
  logic [1:0]  ram_rdata;
  assign dx        = x - x0_q;
  assign dy        = y - y0_q;
  assign hit       = (dx < 11'(SPRITE_DIM)) && (dy < 11'(SPRITE_DIM));
  assign visible   = (state_q == ST_SHOWN) || ((state_q == ST_BLINK) && !blink_phase_q);
  assign ram_raddr = {dy[3:0], dx[3:0]};

  powerup_sprite_ctrl_ram #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (2)
  ) u_bitmap (
    .clk   (clk),
    .we    (bm_we),
    .waddr (wr_data[7:0]),
    .wdata (wr_data[9:8]),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  logic          hit_q;
  logic [CD-1:0] si_rgb_q, so_rgb_q, colour;

  // Stage 1: index 0 is transparent, otherwise the palette colour replaces the upstream pixel.
  always_comb begin
    colour = si_rgb_q;
    if (hit_q) begin
      case (ram_rdata)
        2'd1:    colour = pal1;
        2'd2:    colour = pal2;
        2'd3:    colour = pal3;
        default: ;
      endcase
    end
  end

  // Pixel pipeline registers, cleared so the overlay outputs black during reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_q    <= 1'b0;
      si_rgb_q <= '0;
      so_rgb_q <= '0;
    end else begin
      hit_q    <= hit && visible;
      si_rgb_q <= si_rgb;
      so_rgb_q <= colour;
    end
  end

  assign so_rgb  = so_rgb_q;
  assign expired = expired_q;

  logic unused_wr_hi;
  assign unused_wr_hi = ^wr_data[31:16];

endmodule

// File: tb/tb_powerup_sprite_ctrl.sv
// Testbench for powerup_sprite_ctrl: randomized scan and bus traffic against a frame-count model.
module tb_powerup_sprite_ctrl;

  localparam int BF   = 60;
  localparam int LOG2 = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cs = 1'b0;
  logic        write = 1'b0;
  logic [4:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic        frame_start = 1'b0;
  logic [10:0] x = '0;
  logic [10:0] y = '0;
  logic [11:0] si_rgb = '0;
  logic [11:0] so_rgb;
  logic        expired;

  powerup_sprite_ctrl #(.CD(12), .BLINK_FRAMES(BF), .BLINK_PERIOD_LOG2(LOG2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .cs          (cs),
    .write       (write),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_data     (rd_data),
    .frame_start (frame_start),
    .x           (x),
    .y           (y),
    .si_rgb      (si_rgb),
    .so_rgb      (so_rgb),
    .expired     (expired)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: remaining frames, frames spent blinking, expiry pending/flag.
  logic [1:0]  bmp [256];
  logic [11:0] pal_m [4];
  logic [10:0] x0_m, y0_m;
  int          rem_m, bn_m;
  bit          pend_m, exp_m;
  logic [11:0] pe [2];
  bit          pv [2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit vis_m();
    if (rem_m > BF) return 1'b1;
    if (rem_m > 0)  return ((bn_m >> LOG2) & 1) == 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] status_m();
    logic [1:0] st;
    if (pend_m)          st = 2'd3;
    else if (rem_m == 0) st = 2'd0;
    else if (rem_m > BF) st = 2'd1;
    else                 st = 2'd2;
    return {29'd0, st, exp_m};
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    case (a)
      5'd1: return {21'd0, x0_m};
      5'd2: return {21'd0, y0_m};
      5'd3: return 32'(rem_m);
      5'd4: return status_m();
`ifdef POWERUP_PALETTE_EN
      5'd5: return {20'd0, pal_m[1]};
      5'd6: return {20'd0, pal_m[2]};
      5'd7: return {20'd0, pal_m[3]};
`endif
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    x0_m = '0; y0_m = '0; rem_m = 0; bn_m = 0; pend_m = 0; exp_m = 0;
    pal_m[0] = 12'h000; pal_m[1] = 12'hF00; pal_m[2] = 12'h0F0; pal_m[3] = 12'hFF0;
    pv[0] = 0; pv[1] = 0;
  endtask

  // One clock: check the pixel due now, drive this cycle's inputs, advance the model.
  task automatic cyc(input bit wr, input logic [4:0] a, input logic [31:0] d, input bit fs,
                     input logic [10:0] px, input logic [10:0] py, input logic [11:0] si);
    logic [10:0] dx, dy;
    logic [1:0]  idx;
    logic [11:0] ex;
    if (pv[1]) chk("pixel", so_rgb, pe[1]);
    chk("expired_pin", expired, exp_m);
    cs = wr; write = wr; addr = a; wr_data = d; frame_start = fs;
    x = px; y = py; si_rgb = si;
`ifdef POWERUP_PALETTE_EN
    if (wr && a >= 5'd5 && a <= 5'd7) pal_m[a - 5'd4] = d[11:0];
`endif
    dx = px - x0_m; dy = py - y0_m;
    idx = bmp[{dy[3:0], dx[3:0]}];
    ex = (dx < 16 && dy < 16 && vis_m() && idx != 2'd0) ? pal_m[idx] : si;
    pe[1] = pe[0]; pv[1] = pv[0]; pe[0] = ex; pv[0] = 1'b1;
    if (wr && a == 5'd0) bmp[d[7:0]] = d[9:8];
    if (wr && a == 5'd1) x0_m = d[10:0];
    if (wr && a == 5'd2) y0_m = d[10:0];
    if (wr && a == 5'd4 && d[0]) exp_m = 1'b0;
    if (pend_m) exp_m = 1'b1;
    if (wr && a == 5'd3) begin
      rem_m = int'(d[15:0]); bn_m = 0; pend_m = 1'b0;
    end else if (pend_m) begin
      pend_m = 1'b0;
    end else if (fs && rem_m > 0) begin
      if (rem_m <= BF) bn_m++;
      rem_m--;
      if (rem_m == 0) pend_m = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0, x, y, 12'($urandom));
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] a, input logic [31:0] e);
    cs = 1'b1; write = 1'b0; addr = a;
    #1;
    chk(tag, rd_data, e);
    cs = 1'b0;
  endtask

  task automatic scan(input logic [10:0] px, input logic [10:0] py, input logic [11:0] si, input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, px, py, si);
  endtask

  task automatic do_reset();
    cs = 0; write = 0; frame_start = 0;
    reset_n = 1'b0;
    #1;
    chk("rst_so_rgb", so_rgb, 32'd0);
    chk("rst_expired", expired, 32'd0);
    rd_chk("rst_status", 5'd4, 32'd0);
    rd_chk("rst_x0", 5'd1, 32'd0);
    rd_chk("rst_life", 5'd3, 32'd0);
    model_reset();
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic random_phase(input int n);
    int r;
    logic [10:0] px, py;
    logic [31:0] d;
    logic [4:0]  a;
    for (int i = 0; i < n; i++) begin
      r  = $urandom_range(0, 99);
      px = x0_m + 11'($urandom_range(0, 23)) - 11'd4;
      py = y0_m + 11'($urandom_range(0, 23)) - 11'd4;
      if (r < 12)      begin a = 5'd0; d = {22'd0, 2'($urandom), 8'($urandom)}; end
      else if (r < 14) begin a = 5'd3; d = 32'($urandom_range(0, 120)); end
      else if (r < 16) begin a = 5'd4; d = 32'($urandom_range(0, 1)); end
      else if (r < 17) begin a = 5'($urandom_range(1, 2)); d = 32'($urandom_range(0, 2047)); end
      else if (r < 18) begin a = 5'($urandom_range(8, 31)); d = $urandom; end
      else             begin a = 5'd31; d = 32'd0; end
      cyc(r < 18, a, d, $urandom_range(0, 3) == 0, px, py, 12'($urandom));
      if ($urandom_range(0, 9) == 0) begin
        a = 5'($urandom_range(0, 31));
        rd_chk("rand_read", a, exp_rd(a));
      end
    end
  endtask

  initial begin
    logic [11:0] si;
    model_reset();
    @(negedge clk);
    do_reset();

    // Fill the bitmap with random indices while the sprite is idle (pass-through).
    for (int i = 0; i < 256; i++)
      cyc(1'b1, 5'd0, {22'd0, 2'($urandom), 8'(i)}, 1'b0,
          11'($urandom), 11'($urandom), 12'($urandom));

    wr_reg(5'd1, 32'd100);
    wr_reg(5'd2, 32'd50);
    wr_reg(5'd3, 32'd200);
    rd_chk("x0", 5'd1, 32'd100);
    rd_chk("y0", 5'd2, 32'd50);
    rd_chk("status_shown", 5'd4, 32'h2);
    wr_reg(5'd0, {22'd0, 2'd1, 8'h00});
    scan(11'd100, 11'd50, 12'h123, 3);
    chk("origin_idx1", so_rgb, 32'hF00);
    scan(11'd99, 11'd50, 12'h456, 3);
    chk("left_miss", so_rgb, 32'h456);
    scan(11'd116, 11'd50, 12'h789, 3);
    chk("right_miss", so_rgb, 32'h789);
    wr_reg(5'd0, {22'd0, 2'd0, 8'h00});
    scan(11'd100, 11'd50, 12'h0AB, 3);
    chk("transparent", so_rgb, 32'h0AB);
    wr_reg(5'd0, {22'd0, 2'd3, 8'h00});
    scan(11'd100, 11'd50, 12'h0CD, 3);
    chk("origin_idx3", so_rgb, 32'hFF0);

    random_phase(2000);

    // Lifetime walk: 70 frames, blink after 10, blink phase flips every 8 frames.
    wr_reg(5'd4, 32'd1);
    wr_reg(5'd1, 32'd100);
    wr_reg(5'd2, 32'd50);
    wr_reg(5'd0, {22'd0, 2'd2, 8'h11});
    wr_reg(5'd3, 32'd70);
    si = 12'h123;
    for (int f = 1; f <= 70; f++) begin
      cyc(1'b0, 5'd0, 32'd0, 1'b1, 11'd101, 11'd51, si);
      scan(11'd101, 11'd51, si, 2);
      if (f == 9)  rd_chk("still_shown", 5'd4, 32'h2);
      if (f == 10) begin
        rd_chk("blink_state", 5'd4, 32'h4);
        rd_chk("blink_life", 5'd3, 32'd60);
      end
      if (f == 17) chk("blink_on", so_rgb, 32'h0F0);
      if (f == 18) chk("blink_off", so_rgb, 32'h123);
      if (f == 26) chk("blink_on2", so_rgb, 32'h0F0);
    end
    rd_chk("expired_status", 5'd4, 32'h1);
    chk("expired_out", expired, 32'd1);
    wr_reg(5'd4, 32'd1);
    rd_chk("expired_clear", 5'd4, 32'h0);

    // Life write colliding with frame_start: no decrement.
    wr_reg(5'd3, 32'd200);
    cyc(1'b1, 5'd3, 32'd123, 1'b1, x, y, si);
    rd_chk("write_beats_frame", 5'd3, 32'd123);
    wr_reg(5'd3, 32'd0);
    rd_chk("abort_idle", 5'd4, 32'h0);
    chk("abort_no_expire", expired, 32'd0);

    // Reset in the middle of blinking.
    wr_reg(5'd3, 32'd30);
    for (int f = 0; f < 3; f++) cyc(1'b0, 5'd0, 32'd0, 1'b1, 11'd101, 11'd51, si);
    do_reset();
    scan(11'd1, 11'd1, 12'h321, 3);
    chk("post_reset_hidden", so_rgb, 32'h321);

    // Palette register 6.
    wr_reg(5'd6, 32'h00F);
`ifdef POWERUP_PALETTE_EN
    rd_chk("pal2_read", 5'd6, 32'h00F);
`else
    rd_chk("pal2_read", 5'd6, 32'h0);
`endif
    wr_reg(5'd0, {22'd0, 2'd2, 8'h22});
    wr_reg(5'd3, 32'd500);
    scan(11'd2, 11'd2, 12'h555, 3);
`ifdef POWERUP_PALETTE_EN
    chk("pal2_pixel", so_rgb, 32'h00F);
`else
    chk("pal2_pixel", so_rgb, 32'h0F0);
`endif
    rd_chk("unused_read", 5'd20, 32'h0);
    rd_chk("bitmap_read", 5'd0, 32'h0);

    random_phase(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
